shadow32_dec: RTL and testbench



---
 rtl/shadow32_dec.sv | 129 ++++++++++++
 tb/tb_shadow32_dec.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/shadow32_dec.sv
// Iterative Shadow-32 decryption core: 32-bit block, 64-bit key, one round per clock.
// Optional last-key cache enabled by defining SHADOW_DEC_KEYCACHE_EN.
module shadow32_dec #(
  parameter int unsigned ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [63:0] key,
  input  logic [31:0] ct,
  output logic        busy,
  output logic        done,
  output logic [31:0] pt
);

  localparam int unsigned IDX_W = 5;
  localparam logic [IDX_W-1:0] LAST_R    = IDX_W'(ROUNDS - 1);
  localparam logic [IDX_W-1:0] LAST_ROLL = IDX_W'(ROUNDS - 2);

  typedef enum logic [1:0] {IDLE, KEYROLL, ROUND} state_t;

  state_t           fsm;
  logic [31:0]      blk;
  logic [63:0]      kreg;
  logic [IDX_W-1:0] cnt;
  logic [IDX_W-1:0] r;

  function automatic logic [7:0] f8(input logic [7:0] x);
    return ({x[6:0], x[7]} & {x[0], x[7:1]}) ^ {x[5:0], x[7:6]};
  endfunction

  // Inverse round on {P,Q,R,S} and both key-schedule directions
  logic [7:0]  inv_b_c, inv_d_c;
  logic [31:0] inv_blk_c;
  logic [63:0] fwd_key_c, inv_tmp_c, inv_key_c;
  logic [IDX_W-1:0] r_dec_c;
  logic        last_roll_c;

  assign inv_b_c     = blk[15:8] ^ f8(blk[23:16]) ^ kreg[63:56];
  assign inv_d_c     = blk[31:24] ^ f8(blk[7:0]) ^ kreg[55:48];
  assign inv_blk_c   = {blk[23:16], inv_b_c, blk[7:0], inv_d_c};
  assign fwd_key_c   = {kreg[55:0], kreg[63:56]} ^ {59'b0, cnt};
  assign r_dec_c     = r - IDX_W'(1);
  assign inv_tmp_c   = kreg ^ {59'b0, r_dec_c};
  assign inv_key_c   = {inv_tmp_c[7:0], inv_tmp_c[63:8]};
  assign last_roll_c = (fsm == KEYROLL) && (cnt == LAST_ROLL);

  logic        hit_c;
  logic [63:0] load_key_c;

`ifdef SHADOW_DEC_KEYCACHE_EN
  logic [63:0] cache_key;
  logic [63:0] cache_klast;
  logic        cache_vld;

  assign hit_c      = cache_vld && (key == cache_key);
  assign load_key_c = hit_c ? cache_klast : key;

  // Key tag captured on a miss; entry becomes valid once the roll-forward finishes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cache_key   <= '0;
      cache_klast <= '0;
      cache_vld   <= 1'b0;
    end else if (fsm == IDLE && start && !hit_c) begin
      cache_key <= key;
      cache_vld <= 1'b0;
    end else if (last_roll_c) begin
      cache_klast <= fwd_key_c;
      cache_vld   <= 1'b1;
    end
  end
`else
  assign hit_c      = 1'b0;
  assign load_key_c = key;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm  <= IDLE;
      blk  <= '0;
      kreg <= '0;
      cnt  <= '0;
      r    <= '0;
      busy <= 1'b0;
      done <= 1'b0;
      pt   <= '0;
    end else begin
      done <= 1'b0;
      case (fsm)
        IDLE: begin
          if (start) begin
            blk  <= ct;
            kreg <= load_key_c;
            cnt  <= '0;
            busy <= 1'b1;
            if (hit_c) begin
              r   <= LAST_R;
              fsm <= ROUND;
            end else begin
              fsm <= KEYROLL;
            end
          end
        end
        KEYROLL: begin
          kreg <= fwd_key_c;
          cnt  <= cnt + IDX_W'(1);
          if (last_roll_c) begin
            r   <= LAST_R;
            fsm <= ROUND;
          end
        end
        ROUND: begin
          blk  <= inv_blk_c;
          kreg <= inv_key_c;
          r    <= r_dec_c;
          if (r == '0) begin
            pt   <= inv_blk_c;
            done <= 1'b1;
            busy <= 1'b0;
            fsm  <= IDLE;
          end
        end
        default: fsm <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shadow32_dec.sv
// Bench for shadow32_dec: forward-cipher model feeds a plaintext scoreboard.
// Latency expectations follow SHADOW_DEC_KEYCACHE_EN when it is defined.
module tb_shadow32_dec;

  localparam int unsigned ROUNDS = 16;

  logic        clk, rst;
  logic        start, busy, done;
  logic [63:0] key;
  logic [31:0] ct, pt;
  logic        start2, busy2, done2;
  logic [63:0] key2;
  logic [31:0] ct2, pt2;

  int n_tests = 0;
  int n_fail  = 0;
  int exp_lat;
  logic [31:0] sb_q[$];
`ifdef SHADOW_DEC_KEYCACHE_EN
  bit          m_vld = 0;
  logic [63:0] m_key = '0;
`endif

  shadow32_dec #(.ROUNDS(ROUNDS)) u_dut (
    .clk(clk), .rst(rst), .start(start), .key(key), .ct(ct),
    .busy(busy), .done(done), .pt(pt));

  shadow32_dec #(.ROUNDS(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .key(key2), .ct(ct2),
    .busy(busy2), .done(done2), .pt(pt2));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [7:0] mf(input logic [7:0] x);
    logic [7:0] a, b, c;
    a = (x << 1) | (x >> 7);
    b = (x << 7) | (x >> 1);
    c = (x << 2) | (x >> 6);
    return (a & b) ^ c;
  endfunction

  function automatic logic [31:0] enc(input logic [31:0] p, input logic [63:0] k0, input int rounds);
    logic [63:0] k;
    logic [7:0]  a, b, c, d;
    logic [31:0] s;
    k = k0;
    s = p;
    for (int i = 0; i < rounds; i++) begin
      a = s[31:24]; b = s[23:16]; c = s[15:8]; d = s[7:0];
      s = {d ^ mf(c) ^ k[55:48], a, b ^ mf(a) ^ k[63:56], c};
      k = {k[55:0], k[63:56]} ^ {59'b0, 5'(i)};
    end
    return s;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
`ifdef SHADOW_DEC_KEYCACHE_EN
    m_vld = 0;
`endif
  endtask

  // Called at a negedge; the following posedge is the accepting edge
  task automatic drive_start(input logic [63:0] k, input logic [31:0] p);
    bit hit;
    hit = 0;
`ifdef SHADOW_DEC_KEYCACHE_EN
    hit = m_vld && (k == m_key);
    if (!hit) begin
      m_key = k;
      m_vld = 1;
    end
`endif
    exp_lat = hit ? ROUNDS : 2 * ROUNDS - 1;
    key   = k;
    ct    = enc(p, k, ROUNDS);
    start = 1'b1;
    sb_q.push_back(p);
  endtask

  // Returns at the negedge of the done cycle (or after the cycle budget)
  task automatic wait_done(input string tag, input bit hold);
    int lat, bcnt;
    bit seen;
    logic [31:0] e;
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    check({tag, "_busy_accept"}, 64'(busy), 64'd1);
    bcnt = 1; lat = 0; seen = 0;
    while (lat < 80 && !seen) begin
      @(posedge clk);
      lat++;
      #1;
      if (hold && lat == 5) begin
        key = {$urandom, $urandom};
        ct  = $urandom;
      end
      @(negedge clk);
      if (done) seen = 1;
      else if (busy) bcnt++;
    end
    check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
    check({tag, "_busy_cycles"}, 64'(bcnt), 64'(exp_lat));
    e = sb_q.pop_front();
    if (seen) check({tag, "_pt"}, 64'(pt), 64'(e));
    if (hold) start = 1'b0;
  endtask

  initial begin
    int lat2, bcnt2, spurious;
    logic [63:0] ka, kb;
    rst = 1'b1; start = 1'b0; key = '0; ct = '0;
    start2 = 1'b0; key2 = '0; ct2 = '0;
    #1;
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_done", 64'(done), 64'd0);
    check("reset_pt",   64'(pt),   64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Minimum-round instance: zero key, zero ciphertext
    @(negedge clk);
    start2 = 1'b1; key2 = '0; ct2 = '0;
    @(posedge clk);
    #1 start2 = 1'b0;
    bcnt2 = 1; lat2 = 0;
    while (lat2 < 20 && !done2) begin
      @(posedge clk);
      lat2++;
      @(negedge clk);
      if (!done2 && busy2) bcnt2++;
    end
    check("r2_latency", 64'(lat2), 64'd3);
    check("r2_busy_cycles", 64'(bcnt2), 64'd3);
    check("r2_pt", 64'(pt2), 64'd0);
    @(negedge clk);
    check("r2_done_width", 64'(done2), 64'd0);

    // Random encrypt/decrypt round trips
    for (int i = 0; i < 1000; i++) begin
      drive_start({$urandom, $urandom}, $urandom);
      wait_done("rand", 0);
      @(negedge clk);
    end

    // start held high with inputs changing mid-run
    drive_start(64'hDEAD_BEEF_0BAD_F00D, 32'hCAFE_1234);
    wait_done("hold", 1);
    @(negedge clk);
    check("hold_single_done", 64'(done), 64'd0);
    check("hold_no_reaccept", 64'(busy), 64'd0);

    // Asynchronous reset mid-run
    drive_start(64'h1111_2222_3333_4444, 32'h5555_6666);
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_done", 64'(done), 64'd0);
    check("abort_pt",   64'(pt),   64'd0);
    void'(sb_q.pop_front());
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    spurious = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) spurious++;
    end
    check("abort_no_done", 64'(spurious), 64'd0);
    drive_start(64'h0123_4567_89AB_CDEF, 32'h0BAD_CAFE);
    wait_done("after_rst", 0);
    @(negedge clk);

    // Back-to-back: new start in the done cycle
    ka = 64'hA5A5_5A5A_0F0F_F0F0;
    drive_start(ka, 32'h1357_9BDF);
    wait_done("b2b_first", 0);
    drive_start(ka, 32'h2468_ACE0);
    wait_done("b2b_second", 0);
    @(negedge clk);

    // Key reuse, key change, and reuse across reset
    kb = 64'hFEDC_BA98_7654_3210;
    drive_start(kb, 32'h0000_0001);
    wait_done("key_new", 0);
    @(negedge clk);
    drive_start(kb, 32'hFFFF_FFFF);
    wait_done("key_same", 0);
    @(negedge clk);
    drive_start(ka, 32'h8000_0000);
    wait_done("key_changed", 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    drive_start(ka, 32'h7FFF_FFFF);
    wait_done("key_after_rst", 0);
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
